// File: rtl/alu_pkg.sv
// Shared definitions for the execute stage: ALU op encodings, condition-code
// layout and the default datapath width / "no register" destination ID.
package alu_pkg;

    localparam int         DEFAULT_WIDTH = 64;
    localparam logic [3:0] DEFAULT_RNONE = 4'hF;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_XOR = 2'b11
    } alu_op_e;

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } cc_t;

    localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

    function automatic logic op_is_arith(input alu_op_e op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage

// File: rtl/alu_flags.sv
// Combinational ALU: computes the result and the candidate condition codes
// for one instruction; the register stage decides whether they are kept.
module alu_flags
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  alu_op_e          op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o,
    output cc_t              cc_o
);

    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic             add_ovf;

    // SUB shares the adder as a + ~b + 1, so one overflow rule covers both:
    // overflow when the effective operands agree in sign but the sum does not.
    always_comb begin
        is_sub  = (op_i == ALU_SUB);
        b_eff   = is_sub ? ~b_i : b_i;
        sum     = a_i + b_eff + {{(WIDTH-1){1'b0}}, is_sub};
        add_ovf = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
    end

    always_comb begin
        result_o = '0;
        case (op_i)
            ALU_ADD,
            ALU_SUB: result_o = sum;
            ALU_AND: result_o = a_i & b_i;
            ALU_XOR: result_o = a_i ^ b_i;
            default: result_o = '0;
        endcase
    end

    always_comb begin
        cc_o    = '0;
        cc_o.zf = (result_o == '0);
        cc_o.sf = result_o[WIDTH-1];
        cc_o.of = op_is_arith(op_i) ? add_ovf : 1'b0;
    end

endmodule

// File: rtl/exec_stage_reg.sv
// Execute stage with its output register: ALU result, destination ID and
// condition codes, controlled by reset > stall > bubble > load priority.
module exec_stage_reg
    import alu_pkg::*;
#(
    parameter int         WIDTH = DEFAULT_WIDTH,
    parameter logic [3:0] RNONE = DEFAULT_RNONE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_set_cc,
    input  logic [3:0]       in_dst,
    input  logic             stall,
    input  logic             bubble,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_dst,
    output logic             cc_zf,
    output logic             cc_sf,
    output logic             cc_of
);

    logic [WIDTH-1:0] alu_result;
    cc_t              alu_cc;

    logic             valid_q,  valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       dst_q,    dst_d;
    cc_t              cc_q,     cc_d;

    alu_flags #(
        .WIDTH (WIDTH)
    ) u_alu (
        .op_i     (alu_op_e'(in_op)),
        .a_i      (in_a),
        .b_i      (in_b),
        .result_o (alu_result),
        .cc_o     (alu_cc)
    );

    // Flags are only touched by an accepted valid instruction asking for them;
    // a bubble or an empty slot clears the payload but leaves the flags alone.
    always_comb begin
        valid_d  = valid_q;
        result_d = result_q;
        dst_d    = dst_q;
        cc_d     = cc_q;
        if (!stall) begin
            if (bubble || !in_valid) begin
                valid_d  = 1'b0;
                result_d = '0;
                dst_d    = RNONE;
            end else begin
                valid_d  = 1'b1;
                result_d = alu_result;
                dst_d    = in_dst;
                if (in_set_cc) begin
                    cc_d = alu_cc;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            dst_q    <= RNONE;
            cc_q     <= CC_RESET;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            dst_q    <= dst_d;
            cc_q     <= cc_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_result = result_q;
    assign out_dst    = dst_q;
    assign cc_zf      = cc_q.zf;
    assign cc_sf      = cc_q.sf;
    assign cc_of      = cc_q.of;

endmodule
